// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: filtered line sampling, 11-bit frame check, E0/F0
// prefix decoding, N-slot held-key table and a first-word fall-through event FIFO.
module ps2_key_tracker #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int NUM_SLOTS   = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ps2_clk,
  input  logic                   ps2_dat,
  output logic [7:0]             rx_byte,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic [9:0]             evt_data,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [NUM_SLOTS-1:0]   key_on,
  output logic [9*NUM_SLOTS-1:0] key_code,
  output logic                   tbl_ovf,
  output logic                   fifo_ovf
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PAR = 2'd2, ST_STOP = 2'd3;

  // ---------------- input conditioning (line 0 = clock, line 1 = data)
  logic [1:0] raw, filt;
  assign raw = {ps2_dat, ps2_clk};

  for (genvar g = 0; g < 2; g++) begin : g_line
    logic s1, s2, f;
    logic [FW-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1 <= 1'b1; s2 <= 1'b1; f <= 1'b1; cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 == f) cnt <= '0;
        else if (cnt == FW'(FILTER_LEN - 1)) begin
          f   <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
    assign filt[g] = f;
  end

  logic clk_q, strobe, dat;
  always_ff @(posedge clk or negedge rst)
    if (!rst) clk_q <= 1'b1;
    else      clk_q <= filt[0];
  assign strobe = clk_q & ~filt[0];
  assign dat    = filt[1];

  // ---------------- frame FSM
  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE; bcnt <= '0; shreg <= '0; par <= 1'b0; tmo <= '0;
      rx_byte <= '0; rx_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (clr) begin
        state <= ST_IDLE;
        tmo   <= '0;
      end else if (strobe) begin
        tmo <= '0;
        case (state)
          ST_IDLE: if (!dat) begin state <= ST_DATA; bcnt <= '0; end
                   else frame_err <= 1'b1;
          ST_DATA: begin
            shreg <= {dat, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= ST_PAR;
          end
          ST_PAR: begin par <= dat; state <= ST_STOP; end
          default: begin
            // odd parity: data plus parity bit must carry an odd number of ones
            if (dat && ^{shreg, par}) begin rx_byte <= shreg; rx_valid <= 1'b1; end
            else frame_err <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          tmo       <= '0;
        end else tmo <= tmo + 1'b1;
      end
    end
  end

  // ---------------- byte decoder
  logic       ext_f, brk_f, ev_vld, bat, is_drop;
  logic [9:0] ev_data;

  always_comb begin
    is_drop = 1'b0;
    case (rx_byte)
      8'hE1, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_drop = 1'b1;
      default: is_drop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f <= 1'b0; brk_f <= 1'b0; ev_vld <= 1'b0; bat <= 1'b0; ev_data <= '0;
    end else begin
      ev_vld <= 1'b0;
      bat    <= 1'b0;
      if (clr || frame_err) begin
        ext_f <= 1'b0; brk_f <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == 8'hE0)      ext_f <= 1'b1;
        else if (rx_byte == 8'hF0) brk_f <= 1'b1;
        else begin
          ext_f <= 1'b0; brk_f <= 1'b0;
          if (!is_drop) begin
            if (rx_byte == 8'hAA && !ext_f && !brk_f) bat <= 1'b1;
            else begin
              ev_vld  <= 1'b1;
              ev_data <= {brk_f, ext_f, rx_byte};
            end
          end
        end
      end
    end
  end

  // ---------------- key table
  logic [NUM_SLOTS-1:0]      on, match, free_oh;
  logic [NUM_SLOTS-1:0][8:0] code;
  logic                      hit, found, push;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign match[i]           = on[i] && (code[i] == ev_data[8:0]);
    assign key_code[9*i +: 9] = on[i] ? code[i] : 9'h0F0;
  end
  assign hit    = |match;
  assign key_on = on;

  always_comb begin
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (!on[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on <= '0; code <= '0; tbl_ovf <= 1'b0;
    end else if (clr) begin
      on <= '0; tbl_ovf <= 1'b0;
    end else if (bat) begin
      on <= '0;
    end else if (ev_vld) begin
      if (ev_data[9]) on <= on & ~match;
      else if (!hit) begin
        if (found) begin
          on <= on | free_oh;
          for (int i = 0; i < NUM_SLOTS; i++)
            if (free_oh[i]) code[i] <= ev_data[8:0];
        end else tbl_ovf <= 1'b1;
      end
    end
  end

  // typematic repeats of a held key never reach the FIFO
  assign push = ev_vld && (ev_data[9] || !hit) && !clr;

  // ---------------- event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          full, pop, do_push;

  assign evt_valid = (cnt != '0);
  assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign do_push   = push && (!full || pop);
  assign evt_data  = evt_valid ? mem[rp] : 10'h000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_ovf <= 1'b0;
    end else if (clr) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_ovf <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && full && !pop) fifo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= ev_data;

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised, fully synchronous PS/2 keyboard receiver and key-state tracker.
- Oversamples and filters PS2_CLK/PS2_DAT in the system `clk` domain.
- Checks full 11-bit frames: start, 8 data bits, odd parity, stop.
- Decodes E0/F0 prefixes into make/break events for any scan code.
- Keeps an N-slot table of currently held keys and queues events in a FIFO for the game-control logic.
- Replaces fixed-key, PS2_CLK-clocked tracking with a generic N-key-rollover front end. Receive-only; the block never drives `ps2_dat`.

## Interface
Parameters:
- FILTER_LEN, 4 — consecutive equal samples required to accept a level change on ps2_clk/ps2_dat.
- TIMEOUT_CYC, 5000 — clk cycles without a filtered falling edge before a partial frame is abandoned.
- NUM_SLOTS, 4 — key-table entries (1..8).
- FIFO_DEPTH, 8 — event FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of table, FIFO, prefix flags and sticky flags.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_dat  in  1  raw PS/2 data (asynchronous).
- rx_byte  out  8  last good received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte is updated.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.
- evt_data  out  10  {brk, ext, code[7:0]}; brk=1 means release.
- evt_valid  out  1  FIFO non-empty (first-word fall-through).
- evt_ready  in  1  consumer accepts the head entry when evt_valid && evt_ready.
- key_on  out  NUM_SLOTS  slot occupied.
- key_code  out  9*NUM_SLOTS  slot i = bits [9i+8:9i] = {ext, code}.
- tbl_ovf  out  1  sticky: a make was received with the table full.
- fifo_ovf  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
Input conditioning:
- 2-flop synchroniser, then a per-line filter. A filtered line changes only after FILTER_LEN identical consecutive samples.
- A filtered falling edge of ps2_clk is a "bit strobe"; ps2_dat is sampled at the strobe.

Frame FSM (IDLE, DATA, PARITY, STOP):
- IDLE: a strobe with dat=0 → DATA, bit counter=0. A strobe with dat=1 → frame_err, stay in IDLE.
- DATA: shift LSB first. After the 8th strobe → PARITY.
- PARITY: store the bit → STOP.
- STOP: on the strobe, if dat=1 and data^parity has odd weight → byte good. Otherwise frame_err. Either way → IDLE.
- In DATA/PARITY/STOP, TIMEOUT_CYC cycles without a strobe → frame_err, IDLE.
- Any frame error also clears the ext/brk prefix flags.

Byte decoder (good bytes only):
- 0xE0 → ext=1. 0xF0 → brk=1. Neither prefix generates an event.
- 0xE1, 0xFA, 0xEE, 0xFE, 0x00, 0xFF → dropped; prefix flags cleared.
- 0xAA (BAT) with no prefix → all slots cleared; no event.
- Any other byte completes an event {brk, ext, byte}, then ext and brk clear.

Key table:
- Make: if {ext, code} is already in an occupied slot → typematic repeat: no table change, no event pushed. Otherwise write the code to the lowest free slot. If no slot is free, set tbl_ovf and still push the event.
- Break: clear every occupied slot whose code matches. A break for an absent key still pushes an event.
- Free slots read key_code = 0x0F0.

Event FIFO:
- Push on each non-repeat event.
- Push while full and no pop in the same cycle → event dropped, fifo_ovf set.
- Simultaneous push and pop when full → both succeed.

clr:
- Empties the FIFO and table, zeroes ovf flags and prefix flags, forces the frame FSM to IDLE.
- clr has priority over any same-cycle event.

## Timing
Reset values:
- rx_byte=0x00; rx_valid=0; frame_err=0.
- evt_valid=0; evt_data=0x000.
- key_on=0; all key_code=0x0F0.
- tbl_ovf=0; fifo_ovf=0.
- FSM in IDLE; filtered lines=1; FIFO empty.

Latency, with S = cycle the stop-bit strobe is registered:
- rx_valid/rx_byte or frame_err at S+1.
- Table update and FIFO write at S+2.
- evt_valid high at S+3 if the FIFO was empty.
- Strobe occurs FILTER_LEN+2 cycles after the raw ps2_clk falls.

Other rules:
- evt_data is stable while evt_valid && !evt_ready.
- Async reset mid-frame discards the partial byte and prefix state. No frame_err on reset exit.

## Test plan
1. Frame 0x1C, parity 0, stop 1 → rx_byte=0x1C, one rx_valid pulse, evt_data=0x01C, key_on[0]=1, key_code[0]=0x01C.
2. Bytes E0 6B, E0 F0 6B → events 0x16B then 0x36B; slot 0 set, then cleared to 0x0F0.
3. Bytes 1C 1C 1C (typematic) → exactly one event. Then, with NUM_SLOTS=4, makes 1B 23 2B 33 → slots hold 1C, 1B, 23, 2B, and tbl_ovf=1 on 0x33.
4. Frame 0x1C with wrong parity 1 → frame_err pulse, no rx_valid. Frame abandoned after 4 bits → frame_err at TIMEOUT_CYC, next frame 0x32 decodes correctly.
5. evt_ready=0 and FIFO_DEPTH+1 distinct makes → evt_valid=1, fifo_ovf=1, first 8 events intact in order. Then push+pop in the same cycle while full → count stays 8.
6. Keys held, then 0xAA → key_on=0, no event. Then clr during a frame → FIFO empty, flags 0, next full frame received correctly.
